// File: rtl/branch_info_queue.sv
// In-order queue of predicted branches between fetch and execute. Each resolve
// pops the oldest entry, trains the predictor and, on a misprediction, redirects
// fetch and discards every younger entry.
module branch_info_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FALLTHRU_OFS = 8
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     push1_valid_i,
  input  logic [31:0]              push1_pc_i,
  input  logic                     push1_pht_i,
  input  logic                     push1_bht_i,
  input  logic                     push1_pred_i,
  input  logic [31:0]              push1_target_i,

  input  logic                     push2_valid_i,
  input  logic [31:0]              push2_pc_i,
  input  logic                     push2_pht_i,
  input  logic                     push2_bht_i,
  input  logic                     push2_pred_i,
  input  logic [31:0]              push2_target_i,

  output logic                     push_ready_o,

  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  input  logic [31:0]              resolve_target_i,
  input  logic                     flush_i,

  output logic                     corr_valid_o,
  output logic [31:0]              corr_addr_o,
  output logic                     corr_pht_branch_flag_o,
  output logic                     corr_bht_branch_flag_o,
  output logic                     corr_branch_flag_o,

  output logic                     mispredict_o,
  output logic [31:0]              redirect_pc_o,

  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pht;
    logic        bht;
    logic        pred;
  } entry_t;

  generate
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("branch_info_queue: DEPTH must be a power of two and at least 4");
    end
  endgenerate

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            corr_valid_q;
  logic [31:0]     corr_addr_q;
  logic            corr_pht_q;
  logic            corr_bht_q;
  logic            corr_flag_q;
  logic            mispredict_q;
  logic [31:0]     redirect_pc_q;

  entry_t          head_entry;
  entry_t          push1_entry;
  entry_t          push2_entry;
  logic [PW-1:0]   tail_plus1;
  logic            push_ready;
  logic            pop;
  logic            dir_wrong;
  logic            tgt_wrong;
  logic            mispredict;
  logic            clear;
  logic            push1_ok;
  logic            push2_ok;
  logic [1:0]      n_push;
  logic [31:0]     fallthru_pc;

  assign head_entry  = mem_q[head_q];
  assign push1_entry = '{pc: push1_pc_i, target: push1_target_i,
                         pht: push1_pht_i, bht: push1_bht_i, pred: push1_pred_i};
  assign push2_entry = '{pc: push2_pc_i, target: push2_target_i,
                         pht: push2_pht_i, bht: push2_bht_i, pred: push2_pred_i};
  assign tail_plus1  = tail_q + PW'(1);

  // Readiness looks only at registered occupancy, so a same-cycle pop never
  // makes room for a push; this keeps push_ready_o off the resolve path.
  assign push_ready  = (count_q <= CW'(DEPTH - 2));

  assign pop         = resolve_valid_i && (count_q != '0);
  assign dir_wrong   = (head_entry.pred != resolve_taken_i);
  assign tgt_wrong   = head_entry.pred && resolve_taken_i &&
                       (head_entry.target != resolve_target_i);
  assign mispredict  = pop && (dir_wrong || tgt_wrong);
  assign fallthru_pc = head_entry.pc + 32'(FALLTHRU_OFS);

  // A redirect or external flush wipes every entry, which also covers the
  // popped head, so same-cycle pushes belong to a discarded path.
  assign clear       = flush_i || mispredict;
  assign push1_ok    = push1_valid_i && push_ready && !clear;
  assign push2_ok    = push1_ok && push2_valid_i;
  assign n_push      = {1'b0, push1_ok} + {1'b0, push2_ok};

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      tail_d  = tail_q + PW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an entry is only read
  // after it has been written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push1_ok) begin
      mem_q[tail_q] <= push1_entry;
    end
    if (push2_ok) begin
      mem_q[tail_plus1] <= push2_entry;
    end
  end

  // Training and redirect outputs: the pulses last one cycle, the payloads
  // hold their previous values between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_valid_q  <= 1'b0;
      corr_addr_q   <= '0;
      corr_pht_q    <= 1'b0;
      corr_bht_q    <= 1'b0;
      corr_flag_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      corr_valid_q <= pop;
      mispredict_q <= mispredict;
      if (pop) begin
        corr_addr_q <= head_entry.pc;
        corr_pht_q  <= head_entry.pht;
        corr_bht_q  <= head_entry.bht;
        corr_flag_q <= resolve_taken_i;
      end
      if (mispredict) begin
        redirect_pc_q <= resolve_taken_i ? resolve_target_i : fallthru_pc;
      end
    end
  end

  assign push_ready_o           = push_ready;
  assign corr_valid_o           = corr_valid_q;
  assign corr_addr_o            = corr_addr_q;
  assign corr_pht_branch_flag_o = corr_pht_q;
  assign corr_bht_branch_flag_o = corr_bht_q;
  assign corr_branch_flag_o     = corr_flag_q;
  assign mispredict_o           = mispredict_q;
  assign redirect_pc_o          = redirect_pc_q;
  assign empty_o                = (count_q == '0);
  assign count_o                = count_q;

endmodule
